// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared types for the tug-of-war round/score controller
// Round state encoding, winner codes and a counter-width helper.
package tow_pkg;

  typedef enum logic [1:0] {
    RESTART   = 2'd0,
    PLAY      = 2'd1,
    POINT     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tug_of_war_ctrl_if.sv
// rtl/tug_of_war_ctrl_if.sv - key/light/score bundle around the round controller
// master drives keys and light state; slave (the controller) drives presses and scores.
interface tug_of_war_ctrl_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
);
  logic                  keyL;
  logic                  keyR;
  logic                  newGame;
  logic [NUM_LIGHTS-1:0] lights;
  logic                  pressL;
  logic                  pressR;
  logic                  fieldReset;
  logic [SCORE_W-1:0]    scoreL;
  logic [SCORE_W-1:0]    scoreR;
  logic [1:0]            winner;
  logic                  gameOver;

  modport master (
    output keyL, keyR, newGame, lights,
    input  pressL, pressR, fieldReset, scoreL, scoreR, winner, gameOver
  );

  modport slave (
    input  keyL, keyR, newGame, lights,
    output pressL, pressR, fieldReset, scoreL, scoreR, winner, gameOver
  );
endinterface

// File: rtl/press_edge.sv
// rtl/press_edge.sv - rising-edge detector for one player key
// History resets to 1 so a key already held at reset release never fires.
module press_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  output logic o_rise
);

  logic r_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= 1'b1;
    end else begin
      r_hist <= i_key;
    end
  end

  assign o_rise = i_key & ~r_hist;

endmodule

// File: rtl/tug_of_war_ctrl.sv
// rtl/tug_of_war_ctrl.sv - round/score controller for the tug-of-war light row
// Turns keys into gated press pulses, scores edge pushes and sequences restart/game over.
module tug_of_war_ctrl
  import tow_pkg::*;
#(
  parameter int NUM_LIGHTS  = 9,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 3,
  parameter int RESTART_CYC = 4
) (
  input  logic               clk,
  input  logic               reset,
  tug_of_war_ctrl_if.slave   bus
);

  localparam int CNT_W = cnt_width(RESTART_CYC);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RESTART_CYC - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;
  logic [1:0]         r_winner;

  logic w_raw_l;
  logic w_raw_r;
  logic w_pt_l;
  logic w_pt_r;
  logic w_field_reset;
  logic w_game_over;
  logic w_press_l;
  logic w_press_r;
  logic w_unused;

  press_edge u_edge_l (
    .clk    (clk),
    .reset  (reset),
    .i_key  (bus.keyL),
    .o_rise (w_raw_l)
  );

  press_edge u_edge_r (
    .clk    (clk),
    .reset  (reset),
    .i_key  (bus.keyR),
    .o_rise (w_raw_r)
  );

  // Simultaneous rises cancel, so a point needs a lone rise at the lit edge.
  assign w_pt_l = (r_state == PLAY) & bus.lights[NUM_LIGHTS-1] & w_raw_l & ~w_raw_r;
  assign w_pt_r = (r_state == PLAY) & bus.lights[0]            & w_raw_r & ~w_raw_l;
  assign w_unused = ^bus.lights;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESTART;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RESTART:   if (r_cnt == CNT_LAST) w_state_nxt = PLAY;
      PLAY:      if (w_pt_l || w_pt_r) w_state_nxt = POINT;
      POINT:     w_state_nxt = ((r_score_l == WIN_VAL) || (r_score_r == WIN_VAL))
                               ? GAME_OVER : RESTART;
      GAME_OVER: if (bus.newGame) w_state_nxt = RESTART;
      default:   w_state_nxt = RESTART;
    endcase
  end

  always_comb begin
    w_field_reset = (r_state == RESTART);
    w_game_over   = (r_state == GAME_OVER);
    w_press_l     = 1'b0;
    w_press_r     = 1'b0;
    if (r_state == PLAY) begin
      w_press_l = w_raw_l & ~w_raw_r & ~w_pt_l;
      w_press_r = w_raw_r & ~w_raw_l & ~w_pt_r;
    end
  end

  // Counter idles at zero outside RESTART so every round start sees a full hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == RESTART) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_score_l <= '0;
      r_score_r <= '0;
      r_winner  <= WIN_NONE;
    end else if (w_pt_l) begin
      r_score_l <= r_score_l + SCORE_W'(1);
      r_winner  <= WIN_LEFT;
    end else if (w_pt_r) begin
      r_score_r <= r_score_r + SCORE_W'(1);
      r_winner  <= WIN_RIGHT;
    end else if ((r_state == GAME_OVER) && bus.newGame) begin
      r_score_l <= '0;
      r_score_r <= '0;
      r_winner  <= WIN_NONE;
    end
  end

  assign bus.pressL     = w_press_l;
  assign bus.pressR     = w_press_r;
  assign bus.fieldReset = w_field_reset;
  assign bus.gameOver   = w_game_over;
  assign bus.scoreL     = r_score_l;
  assign bus.scoreR     = r_score_r;
  assign bus.winner     = r_winner;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// tb/tb_tug_of_war_ctrl.sv - scoreboard bench for the tug-of-war round controller
// Stimulus pushes expected outputs from a game-rules model; a monitor pops and compares.
module tb_tug_of_war_ctrl;

  localparam int NL = 9;
  localparam int WS = 7;
  localparam int SW = 3;
  localparam int RC = 4;
  localparam logic [NL-1:0] CENTER = 9'b000010000;
  localparam logic [NL-1:0] LEFTMOST = 9'b100000000;
  localparam logic [NL-1:0] RIGHTMOST = 9'b000000001;

  typedef struct packed {
    logic          pl;
    logic          pr;
    logic          fr;
    logic          go;
    logic [1:0]    win;
    logic [SW-1:0] sl;
    logic [SW-1:0] sr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tug_of_war_ctrl_if #(.NUM_LIGHTS(NL), .SCORE_W(SW)) bus ();

  tug_of_war_ctrl #(
    .NUM_LIGHTS (NL),
    .WIN_SCORE  (WS),
    .SCORE_W    (SW),
    .RESTART_CYC(RC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Game-rules model: phase 0 holding field, 1 playing, 2 point scored, 3 game over.
  int m_phase;
  int m_hold_left;
  int m_sl;
  int m_sr;
  int m_win;
  bit m_hist_l;
  bit m_hist_r;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t g;
      e = q.pop_front();
      g = '{pl: bus.pressL, pr: bus.pressR, fr: bus.fieldReset, go: bus.gameOver,
            win: bus.winner, sl: bus.scoreL, sr: bus.scoreR};
      chk("outputs{pl,pr,fr,go,win,sl,sr}", 32'(g), 32'(e));
    end
  end

  task automatic step(input bit rst, input bit kl, input bit kr, input bit ng,
                      input logic [NL-1:0] li);
    exp_t e;
    bit   rise_l, rise_r, lone_l, lone_r, pt_l, pt_r;
    @(posedge clk);
    #1;
    reset = rst; bus.keyL = kl; bus.keyR = kr; bus.newGame = ng; bus.lights = li;
    if (!rst) begin
      m_phase = 0; m_hold_left = RC; m_sl = 0; m_sr = 0; m_win = 0;
      m_hist_l = 1'b1; m_hist_r = 1'b1;
      e = '{pl: 1'b0, pr: 1'b0, fr: 1'b1, go: 1'b0, win: 2'd0, sl: '0, sr: '0};
      q.push_back(e);
      return;
    end
    rise_l = kl && !m_hist_l;
    rise_r = kr && !m_hist_r;
    lone_l = rise_l && !rise_r;
    lone_r = rise_r && !rise_l;
    pt_l = (m_phase == 1) && li[NL-1] && lone_l;
    pt_r = (m_phase == 1) && li[0] && lone_r;
    e.pl  = (m_phase == 1) && lone_l && !pt_l;
    e.pr  = (m_phase == 1) && lone_r && !pt_r;
    e.fr  = (m_phase == 0);
    e.go  = (m_phase == 3);
    e.win = 2'(m_win);
    e.sl  = SW'(m_sl);
    e.sr  = SW'(m_sr);
    q.push_back(e);
    m_hist_l = kl;
    m_hist_r = kr;
    case (m_phase)
      0: begin
        m_hold_left--;
        if (m_hold_left == 0) m_phase = 1;
      end
      1: begin
        if (pt_l) begin m_sl++; m_win = 1; m_phase = 2; end
        else if (pt_r) begin m_sr++; m_win = 2; m_phase = 2; end
      end
      2: begin
        if (m_sl == WS || m_sr == WS) m_phase = 3;
        else begin m_phase = 0; m_hold_left = RC; end
      end
      default: begin
        if (ng) begin m_sl = 0; m_sr = 0; m_win = 0; m_phase = 0; m_hold_left = RC; end
      end
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, CENTER);
  endtask

  task automatic wait_play();
    for (int i = 0; i < 20 && m_phase != 1; i++) idle(1);
  endtask

  task automatic score(input bit right);
    idle(1);
    step(1'b1, !right, right, 1'b0, right ? RIGHTMOST : LEFTMOST);
    wait_play();
  endtask

  initial begin
    bit kl, kr, ng;
    logic [NL-1:0] li;
    reset = 1'b0; bus.keyL = 1'b0; bus.keyR = 1'b0; bus.newGame = 1'b0; bus.lights = CENTER;

    // Reset release and the field hold that follows.
    step(1'b0, 1'b0, 1'b0, 1'b0, CENTER);
    step(1'b0, 1'b0, 1'b0, 1'b0, CENTER);
    idle(1);
    @(negedge clk); chk("t1_fieldreset_first", 32'(bus.fieldReset), 32'd1);
    idle(3);
    @(negedge clk); chk("t1_fieldreset_fourth", 32'(bus.fieldReset), 32'd1);
    idle(1);
    @(negedge clk); chk("t1_fieldreset_off", 32'(bus.fieldReset), 32'd0);
    chk("t1_scores", 32'({bus.scoreL, bus.scoreR, bus.winner}), 32'd0);

    // Held key yields a single pulse.
    step(1'b1, 1'b1, 1'b0, 1'b0, CENTER);
    @(negedge clk); chk("t2_pressL_rise", 32'(bus.pressL), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, CENTER);
    @(negedge clk); chk("t2_pressL_held", 32'(bus.pressL), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, CENTER);
    @(negedge clk); chk("t2_scoreL", 32'(bus.scoreL), 32'd0);

    // Left point at the left edge.
    step(1'b1, 1'b0, 1'b0, 1'b0, LEFTMOST);
    step(1'b1, 1'b1, 1'b0, 1'b0, LEFTMOST);
    @(negedge clk); chk("t3_pressL_gated", 32'(bus.pressL), 32'd0);
    idle(1);
    @(negedge clk); chk("t3_point_cycle", 32'({bus.scoreL, bus.winner, bus.fieldReset}), 32'({3'd1, 2'b01, 1'b0}));
    idle(1);
    @(negedge clk); chk("t3_restart", 32'(bus.fieldReset), 32'd1);
    wait_play();

    // Simultaneous rises cancel.
    idle(1);
    step(1'b1, 1'b1, 1'b1, 1'b0, LEFTMOST);
    @(negedge clk); chk("t4_no_press", 32'({bus.pressL, bus.pressR}), 32'd0);
    idle(1);
    @(negedge clk); chk("t4_no_point", 32'({bus.scoreL, bus.fieldReset}), 32'({3'd1, 1'b0}));

    // Right reaches the winning score, then new game.
    for (int i = 0; i < WS - 1; i++) score(1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, RIGHTMOST);
    idle(1);
    @(negedge clk); chk("t5_scoreR_win", 32'({bus.scoreR, bus.winner}), 32'({3'd7, 2'b10}));
    idle(1);
    @(negedge clk); chk("t5_gameover", 32'({bus.gameOver, bus.fieldReset}), 32'b10);
    step(1'b1, 1'b1, 1'b0, 1'b0, LEFTMOST);
    @(negedge clk); chk("t5_frozen_press", 32'(bus.pressL), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, CENTER);
    idle(1);
    @(negedge clk); chk("t5_newgame", 32'({bus.scoreL, bus.scoreR, bus.fieldReset, bus.gameOver}), 32'b00000010);
    wait_play();

    // Asynchronous reset mid-round with a right key held through release.
    for (int i = 0; i < 3; i++) score(1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, CENTER);
    @(negedge clk); chk("t6_async_reset", 32'({bus.scoreL, bus.fieldReset}), 32'({3'd0, 1'b1}));
    step(1'b0, 1'b0, 1'b1, 1'b0, CENTER);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, RIGHTMOST);
      @(negedge clk); chk("t6_held_no_pressR", 32'({bus.pressR, bus.scoreR}), 32'd0);
    end

    // Randomised play.
    kl = 1'b1; kr = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 199) == 0) begin
        step(1'b0, kl, kr, 1'b0, CENTER);
        continue;
      end
      if ($urandom_range(0, 9) < 3) kl = ~kl;
      if ($urandom_range(0, 9) < 3) kr = ~kr;
      ng = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 9);
      if (r < 3) li = LEFTMOST;
      else if (r < 6) li = RIGHTMOST;
      else li = NL'(1) << $urandom_range(1, NL - 2);
      step(1'b1, kl, kr, ng, li);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
